user_code_capture: RTL and testbench



---
 rtl/ui_pkg.sv | 12 +
 rtl/sync2.sv | 21 ++
 rtl/user_code_capture.sv | 90 +++++++++
 tb/tb_user_code_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared constants and state encoding for the user-code capture front end.
package ui_pkg;
  localparam int CODE_W           = 3;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs, W bits wide.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/user_code_capture.sv
// Debounced confirm button latches the synchronised 3-bit switch code once per press.
module user_code_capture
  import ui_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] sw,
  input  logic              btn,
  input  logic              clr,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              load_pulse
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              btn_s;
  logic [CODE_W-1:0] sw_s;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  sync2 #(.W(1))      u_sync_btn (.clk(clk), .rst(rst), .d(btn), .q(btn_s));
  sync2 #(.W(CODE_W)) u_sync_sw  (.clk(clk), .rst(rst), .d(sw),  .q(sw_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (clr) begin
        // A held button must not count as a fresh press after a clear.
        state      <= btn_s ? S_PRESSED : S_IDLE;
        cnt        <= '0;
        code       <= '0;
        code_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (btn_s) begin
              state <= S_PRESS_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          S_PRESS_WAIT: begin
            if (!btn_s) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state      <= S_PRESSED;
              cnt        <= '0;
              code       <= sw_s;
              code_valid <= 1'b1;
              load_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!btn_s) begin
              state <= S_RELEASE_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          S_RELEASE_WAIT: begin
            if (btn_s) begin
              state <= S_PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_user_code_capture.sv
// Self-checking bench: directed table, hand sequences and random runs against a debounce model.
module tb_user_code_capture;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw  = '0;
  logic       btn = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] code;
  logic       code_valid, load_pulse;

  user_code_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .clr(clr),
    .code(code), .code_valid(code_valid), .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  // Model: debounced level flips after D consecutive disagreeing synchronised samples.
  logic       bh [2];
  logic [2:0] wh [2];
  logic       m_deb;
  int         m_run;
  logic [2:0] m_code;
  logic       m_valid, m_pulse;

  typedef struct {
    logic [2:0] sw;
    logic       btn;
    logic [2:0] ecode;
    logic       evalid;
    logic       epulse;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bh[0] = 0; bh[1] = 0; wh[0] = '0; wh[1] = '0;
    m_deb = 0; m_run = 0; m_code = '0; m_valid = 0; m_pulse = 0;
  endtask

  task automatic tick();
    logic       bs;
    logic [2:0] ws;
    if (rst) model_reset();
    else begin
      bs = bh[1]; ws = wh[1]; m_pulse = 0;
      if (clr) begin
        m_code = '0; m_valid = 0; m_deb = bs; m_run = 0;
      end else if (bs != m_deb) begin
        m_run++;
        if (m_run == D) begin
          m_deb = bs; m_run = 0;
          if (bs) begin m_code = ws; m_valid = 1; m_pulse = 1; end
        end
      end else m_run = 0;
      bh[1] = bh[0]; bh[0] = btn;
      wh[1] = wh[0]; wh[0] = sw;
    end
    @(posedge clk); #1;
    if (load_pulse === 1'b1) pulses++;
    chk("model_code",  code,       m_code);
    chk("model_valid", code_valid, m_valid);
    chk("model_pulse", load_pulse, m_pulse);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_pattern(input logic [31:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      btn = pat[len-1-i];
      tick();
    end
  endtask

  initial begin
    int first;
    int runlen;
    model_reset();

    // Reset with random inputs, then idle after release.
    for (int i = 0; i < 4; i++) begin
      sw = 3'($urandom); btn = 1'($urandom);
      tick();
    end
    chk("rst_code", code, 3'b000);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_pulse", load_pulse, 1'b0);
    btn = 0; rst = 0;
    ticks(4);
    chk("post_rst_valid", code_valid, 1'b0);

    // Clean press: btn first sampled at edge 10, load at edge 15.
    for (int r = 0; r < 20; r++) begin
      int e;
      e = r + 1;
      tbl[r].sw     = 3'b101;
      tbl[r].btn    = (e >= 10);
      tbl[r].ecode  = (e >= 15) ? 3'b101 : 3'b000;
      tbl[r].evalid = (e >= 15);
      tbl[r].epulse = (e == 15);
    end
    for (int r = 0; r < 20; r++) begin
      sw = tbl[r].sw; btn = tbl[r].btn;
      tick();
      chk("tbl_code",  code,       tbl[r].ecode);
      chk("tbl_valid", code_valid, tbl[r].evalid);
      chk("tbl_pulse", load_pulse, tbl[r].epulse);
    end
    pulses = 0;
    ticks(6);
    chk("hold_no_repulse", pulses, 0);
    btn = 0; ticks(8);

    // Bounce rejection, then a single clean 6-cycle press.
    sw = 3'b010; pulses = 0;
    run_pattern(32'b110110000000, 12);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_code", code, 3'b101);
    btn = 1; ticks(6);
    btn = 0; ticks(8);
    chk("press6_pulses", pulses, 1);
    chk("press6_code", code, 3'b010);

    // Release bounce must not reload with the new switch value.
    sw = 3'b011; pulses = 0;
    btn = 1; ticks(8);
    chk("rb_first_code", code, 3'b011);
    sw = 3'b110;
    run_pattern(32'b001000101000000000, 18);
    chk("rb_code_held", code, 3'b011);
    chk("rb_pulses", pulses, 1);
    btn = 1; ticks(8);
    chk("rb_fresh_code", code, 3'b110);
    chk("rb_fresh_pulses", pulses, 2);
    btn = 0; ticks(8);

    // clr on the exact load edge.
    sw = 3'b111; pulses = 0;
    btn = 1; ticks(5);
    clr = 1; tick(); clr = 0;
    chk("clr_code", code, 3'b000);
    chk("clr_valid", code_valid, 1'b0);
    chk("clr_pulse", load_pulse, 1'b0);
    ticks(10);
    chk("clr_held_pulses", pulses, 0);
    btn = 0; ticks(8);
    btn = 1; ticks(8);
    chk("clr_repress_code", code, 3'b111);
    chk("clr_repress_pulses", pulses, 1);
    btn = 0; ticks(8);

    // Async reset while in PRESS_WAIT, with a previously latched code.
    btn = 1; ticks(3);
    #2; rst = 1; model_reset();
    #1;
    chk("async_rst_code", code, 3'b000);
    chk("async_rst_valid", code_valid, 1'b0);
    tick();
    rst = 0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (load_pulse === 1'b1 && first == 0) first = i;
    end
    chk("rst_relatch_edge", first, D + 2);
    btn = 0; ticks(8);

    // Random runs of button levels with occasional clr.
    runlen = 0;
    for (int i = 0; i < 1500; i++) begin
      if (runlen == 0) begin
        btn = ~btn;
        runlen = $urandom_range(1, 8);
      end
      runlen--;
      sw  = 3'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
